arb_client: RTL

Requester-side controller for the two-input registered fair arbiter: buffers jobs from an upstream producer in a small FIFO, drives `req` while work is pending, and on each `grant` pops one job and issues it to the shared resource. It also detects stale grants (grant with nothing queued) and starvation (request held too long without a grant). One instance sits on each arbiter requester port.

---
 rtl/arb_client.sv | 114 +++++++++++
 1 files changed

// File: rtl/arb_client.sv
// arb_client: requester-side controller for a two-input registered arbiter.
// Jobs from upstream are queued in a small FIFO. req is raised while work is
// pending, and each grant pops one job onto out_data/out_valid. The block also
// counts stale grants (a grant that arrives while the FIFO is empty) and flags
// starvation (req held too long without a grant).
module arb_client #(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_valid,
  input  logic [DATA_W-1:0]          push_data,
  output logic                       push_ready,
  output logic                       req,
  input  logic                       grant,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       starve,
  output logic [7:0]                 waste_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     rd_ptr_reg, wr_ptr_reg;
  logic [LW-1:0]     count_reg;
  logic [SW-1:0]     starve_cnt_reg;
  logic [7:0]        waste_reg;
  logic              out_valid_reg;
  logic [DATA_W-1:0] out_data_reg;

  logic do_push, do_pop, stale;

  // Handshake decode. All outputs derive from registered state only, so
  // there is no combinational path from grant or push_valid to req.
  // push_ready folds in reset so nothing is accepted while reset is held.
  assign push_ready = !reset && (count_reg != FULL);
  assign req        = (count_reg != '0);
  assign do_push    = push_valid && push_ready;
  assign do_pop     = grant && req;
  assign stale      = grant && !req;

  assign level     = count_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign waste_cnt = waste_reg;
  assign starve    = (starve_cnt_reg == SLIM);

  // Storage write. The contents are left unreset on purpose: after a reset
  // they are never read until they have been written again.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  // FIFO pointers and occupancy. A push and a pop in the same cycle leave
  // the count unchanged. A push while full is already blocked by
  // push_ready, even if a pop happens in that cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + LW'(1);
        2'b01:   count_reg <= count_reg - LW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Issue stage. A popped job appears on out_data for exactly one cycle
  // after the grant. out_data keeps its last value while out_valid is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      out_valid_reg <= do_pop;
      if (do_pop) out_data_reg <= mem[rd_ptr_reg];
    end
  end

  // Stale-grant counter. It saturates at 255.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      waste_reg <= '0;
    end else if (stale && (waste_reg != 8'hFF)) begin
      waste_reg <= waste_reg + 8'd1;
    end
  end

  // Starvation counter. It counts consecutive cycles with req high and no
  // grant, saturates at the limit, and clears on any grant or when req is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_reg <= '0;
    end else if (req && !grant) begin
      if (starve_cnt_reg != SLIM) starve_cnt_reg <= starve_cnt_reg + SW'(1);
    end else begin
      starve_cnt_reg <= '0;
    end
  end

endmodule
